// File: rtl/subckt_tb_pkg.sv
// Shared definitions for the subcircuit stimulus driver: FSM states,
// polynomial taps and the single-step shift function used by LFSR and MISR.
package subckt_tb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Feedback taps at bits 15, 13, 12 and 10.
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] MISR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // One shift step; din = 0 gives the plain LFSR, din = response gives the MISR.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur,
                                              input logic [15:0] taps,
                                              input logic        din);
        return {cur[14:0], (^(cur & taps)) ^ din};
    endfunction

endpackage

// File: rtl/subckt_misr16.sv
// 16-bit multiple-input signature register compacting one serial response bit
// per enabled cycle; clear has priority over enable.
module subckt_misr16
    import subckt_tb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        enable,
    input  logic        serial_in,
    output logic [15:0] sig
);

    logic [15:0] misr_r;

    // Signature register with synchronous reset and clear.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            misr_r <= 16'h0000;
        end else if (enable) begin
            misr_r <= lfsr_step(misr_r, MISR_TAPS, serial_in);
        end else begin
            misr_r <= misr_r;
        end
    end

    assign sig = misr_r;

endmodule

// File: rtl/subckt_stim_driver.sv
// Drives LFSR patterns into a 4-input subcircuit and compacts its delayed
// response into a MISR signature for comparison with the golden netlist.
module subckt_stim_driver
    import subckt_tb_pkg::*;
#(
    parameter int RESP_LAT = 2
)
(
    input  logic        I1470_clk,
    input  logic        I1477_rst,
    input  logic        start,
    input  logic [15:0] seed,
    input  logic [15:0] num_patterns,
    input  logic        resp_in,
    output logic [3:0]  stim_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] signature
);

    state_t                state_r;
    state_t                state_s;
    logic [15:0]           lfsr_r;
    logic [15:0]           lfsr_s;
    logic [15:0]           cnt_r;
    logic [15:0]           cnt_s;
    logic [RESP_LAT-1:0]   vpipe_r;
    logic [RESP_LAT-1:0]   vpipe_shl_s;
    logic [3:0]            stim_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  misr_clear_s;
    logic                  misr_en_s;

    // State register.
    always_ff @(posedge I1470_clk) begin
        if (I1477_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state, next LFSR and next count.
    always_comb begin
        state_s      = state_r;
        lfsr_s       = lfsr_r;
        cnt_s        = cnt_r;
        vpipe_shl_s  = vpipe_r << 1;
        misr_clear_s = (state_r == ST_LOAD);
        misr_en_s    = vpipe_r[RESP_LAT-1];
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                lfsr_s = (seed == 16'h0000) ? DEFAULT_SEED : seed;
                cnt_s  = num_patterns;
                if (num_patterns != 16'h0000) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_DONE;
                end
            end
            ST_RUN: begin
                lfsr_s = lfsr_step(lfsr_r, LFSR_TAPS, 1'b0);
                cnt_s  = cnt_r - 16'd1;
                if (cnt_r <= 16'd1) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // Leave once only the final stage still holds a pending response.
                if (vpipe_shl_s == {RESP_LAT{1'b0}}) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Datapath registers and outputs, registered from next-state values.
    always_ff @(posedge I1470_clk) begin
        if (I1477_rst) begin
            lfsr_r  <= 16'h0000;
            cnt_r   <= 16'h0000;
            vpipe_r <= {RESP_LAT{1'b0}};
            stim_r  <= 4'h0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            lfsr_r <= lfsr_s;
            cnt_r  <= cnt_s;
            if (state_r == ST_LOAD) begin
                vpipe_r <= {RESP_LAT{1'b0}};
            end else begin
                vpipe_r    <= vpipe_shl_s;
                vpipe_r[0] <= (state_r == ST_RUN);
            end
            stim_r <= (state_s == ST_RUN) ? lfsr_s[3:0] : 4'h0;
            busy_r <= (state_s != ST_IDLE);
            done_r <= (state_s == ST_DONE);
        end
    end

    subckt_misr16 u_misr (
        .clk       (I1470_clk),
        .rst       (I1477_rst),
        .clear     (misr_clear_s),
        .enable    (misr_en_s),
        .serial_in (resp_in),
        .sig       (signature)
    );

    assign stim_out = stim_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_subckt_stim_driver.sv
// Directed bench for subckt_stim_driver with hand-computed patterns,
// done timing and signatures.
module tb_subckt_stim_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] seed;
    logic [15:0] num_patterns;
    logic        resp_in;
    logic [3:0]  stim_out;
    logic        busy;
    logic        done;
    logic [15:0] signature;

    int checks = 0;
    int errors = 0;

    subckt_stim_driver #(.RESP_LAT(2)) dut (
        .I1470_clk    (clk),
        .I1477_rst    (rst),
        .start        (start),
        .seed         (seed),
        .num_patterns (num_patterns),
        .resp_in      (resp_in),
        .stim_out     (stim_out),
        .busy         (busy),
        .done         (done),
        .signature    (signature)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start in the current (IDLE) cycle 0, then check every cycle through one past DONE.
    task automatic run_vec(input string tag, input logic [15:0] sd, input logic [15:0] n,
                           input logic rv, input logic [15:0] stims,
                           input logic [15:0] exp_sig, input int pulse_cyc);
        int         done_at;
        logic [3:0] exp_stim;
        seed         = sd;
        num_patterns = n;
        resp_in      = rv;
        start        = 1'b1;
        done_at      = (n == 16'd0) ? 2 : 4 + int'(n);
        for (int c = 1; c <= done_at + 1; c++) begin
            step();
            start = (c == pulse_cyc);
            if (c == 2) begin
                seed         = 16'hFFFF;
                num_patterns = 16'h0007;
            end
            exp_stim = 4'h0;
            if (c >= 2 && c < 2 + int'(n)) exp_stim = stims[(c-2)*4 +: 4];
            check_eq($sformatf("%s stim c%0d", tag, c), 32'(stim_out), 32'(exp_stim));
            check_eq($sformatf("%s busy c%0d", tag, c), 32'(busy), 32'(c <= done_at));
            check_eq($sformatf("%s done c%0d", tag, c), 32'(done), 32'(c == done_at));
            if (c >= done_at) begin
                check_eq($sformatf("%s sig c%0d", tag, c), 32'(signature), 32'(exp_sig));
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b1;
        seed         = 16'h0001;
        num_patterns = 16'd4;
        resp_in      = 1'b1;

        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("rst busy", 32'(busy), 32'h0);
            check_eq("rst done", 32'(done), 32'h0);
            check_eq("rst stim", 32'(stim_out), 32'h0);
            check_eq("rst sig", 32'(signature), 32'h0);
        end
        rst = 1'b0;
        check_eq("release idle busy", 32'(busy), 32'h0);

        run_vec("basic", 16'h0001, 16'd4, 1'b1, 16'h8421, 16'h000F, 0);
        run_vec("n0",    16'h1234, 16'd0, 1'b1, 16'h0000, 16'h0000, 0);
        run_vec("seed0", 16'h0000, 16'd1, 1'b1, 16'h0001, 16'h0001, 0);
        run_vec("taps",  16'hACE1, 16'd3, 1'b0, 16'h0731, 16'h0000, 0);
        run_vec("pulse", 16'h0001, 16'd4, 1'b1, 16'h8421, 16'h000F, 3);

        // Reset while draining: back to idle, signature cleared, no done pulse.
        seed         = 16'h0001;
        num_patterns = 16'd4;
        resp_in      = 1'b1;
        start        = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step();
            start = 1'b0;
        end
        check_eq("drain busy", 32'(busy), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("mid rst busy", 32'(busy), 32'h0);
        check_eq("mid rst sig", 32'(signature), 32'h0);
        check_eq("mid rst stim", 32'(stim_out), 32'h0);
        for (int c = 0; c < 4; c++) begin
            check_eq($sformatf("mid rst done %0d", c), 32'(done), 32'h0);
            check_eq($sformatf("mid rst idle %0d", c), 32'(busy), 32'h0);
            step();
        end
        run_vec("after_rst", 16'h0001, 16'd4, 1'b1, 16'h8421, 16'h000F, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
